// File: rtl/control_principal_if.sv
// Control bundle between the multi-cycle controller and its datapath/memory.
// master = controller side, slave = datapath side.
interface control_principal_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alu_cond;
  logic       mem_ready;
  logic [1:0] modo;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic [1:0] sel_wb;
  logic [1:0] pc_src;
  logic       sel_addr;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_req;
  logic       mem_we;
  logic       illegal;

  // Memory handshake: a transfer completes in the cycle where mem_req=1 and
  // mem_ready=1; mem_req/mem_we/sel_addr hold steady until that cycle, and
  // mem_ready is meaningless while mem_req=0.
  modport master (
    input  opcode, funct3, alu_cond, mem_ready,
    output modo, sel_a, sel_b, sel_wb, pc_src, sel_addr,
           pc_write, ir_write, reg_write, mem_req, mem_we, illegal
  );

  modport slave (
    output opcode, funct3, alu_cond, mem_ready,
    input  modo, sel_a, sel_b, sel_wb, pc_src, sel_addr,
           pc_write, ir_write, reg_write, mem_req, mem_we, illegal
  );
endinterface

// File: rtl/control_principal.sv
// Multi-cycle RV32I main control FSM; dbg_state exposes the current state
// encoded in declaration order (RESET=0 ... TRAP=15).
module control_principal (
  input  logic                  clk,
  input  logic                  rst_n,
  control_principal_if.master   bus,
  output logic [3:0]            dbg_state
);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_WB_ALU,
    S_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JAL, S_JALR, S_TRAP
  } state_t;

  state_t state, state_nx;

  logic [1:0] modo, sel_a, sel_b, sel_wb, pc_src;
  logic       sel_addr, pc_write, ir_write, reg_write, mem_req, mem_we, illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_RESET;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    modo      = 2'd0;
    sel_a     = 2'd0;
    sel_b     = 2'd0;
    sel_wb    = 2'd0;
    pc_src    = 2'd0;
    sel_addr  = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    illegal   = 1'b0;
    unique case (state)
      S_RESET: state_nx = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (bus.opcode)
          7'b0110011: state_nx = S_EXEC_R;
          7'b0010011: state_nx = S_EXEC_I;
          7'b0000011,
          7'b0100011: state_nx = S_ADDR;
          // funct3 010/011 have no branch encoding
          7'b1100011: state_nx = (bus.funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
          7'b1101111: state_nx = S_JAL;
          7'b1100111: state_nx = S_JALR;
          7'b0110111: state_nx = S_LUI;
          7'b0010111: state_nx = S_AUIPC;
          default:    state_nx = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        modo = 2'd2; sel_a = 2'd1; sel_b = 2'd0;
        state_nx = S_WB_ALU;
      end
      S_EXEC_I: begin
        modo = 2'd1; sel_a = 2'd1; sel_b = 2'd1;
        state_nx = S_WB_ALU;
      end
      S_LUI: begin
        modo = 2'd0; sel_a = 2'd2; sel_b = 2'd1;
        state_nx = S_WB_ALU;
      end
      S_AUIPC: begin
        modo = 2'd0; sel_a = 2'd0; sel_b = 2'd1;
        state_nx = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1; sel_wb = 2'd0; pc_write = 1'b1; pc_src = 2'd0;
        state_nx  = S_FETCH;
      end
      S_ADDR: begin
        modo = 2'd0; sel_a = 2'd1; sel_b = 2'd1;
        state_nx = (bus.opcode == 7'b0100011) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1; sel_addr = 1'b1;
        if (bus.mem_ready) state_nx = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write = 1'b1; sel_wb = 2'd1; pc_write = 1'b1; pc_src = 2'd0;
        state_nx  = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1; mem_we = 1'b1; sel_addr = 1'b1;
        // a store retires in its completion cycle; no separate write-back
        if (bus.mem_ready) begin
          pc_write = 1'b1; pc_src = 2'd0;
          state_nx = S_FETCH;
        end
      end
      S_BRANCH: begin
        modo = 2'd3; sel_a = 2'd1; sel_b = 2'd0;
        pc_write = 1'b1; pc_src = {1'b0, bus.alu_cond};
        state_nx = S_FETCH;
      end
      S_JAL: begin
        reg_write = 1'b1; sel_wb = 2'd2; pc_write = 1'b1; pc_src = 2'd1;
        state_nx  = S_FETCH;
      end
      S_JALR: begin
        modo = 2'd0; sel_a = 2'd1; sel_b = 2'd1;
        reg_write = 1'b1; sel_wb = 2'd2; pc_write = 1'b1; pc_src = 2'd2;
        state_nx  = S_FETCH;
      end
      S_TRAP: begin
        illegal  = 1'b1;
        state_nx = S_TRAP;
      end
      default: state_nx = S_RESET;
    endcase
  end

  assign bus.modo      = modo;
  assign bus.sel_a     = sel_a;
  assign bus.sel_b     = sel_b;
  assign bus.sel_wb    = sel_wb;
  assign bus.pc_src    = pc_src;
  assign bus.sel_addr  = sel_addr;
  assign bus.pc_write  = pc_write;
  assign bus.ir_write  = ir_write;
  assign bus.reg_write = reg_write;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.illegal   = illegal;
  assign dbg_state     = state;

endmodule

// File: tb/tb_control_principal.sv
// Bench for control_principal: per-instruction cycle traces built from the
// instruction-class rules, compared cycle by cycle against the DUT.
module tb_control_principal;

  localparam int ST_RESET = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC_R = 3,
                 ST_EXEC_I = 4, ST_LUI = 5, ST_AUIPC = 6, ST_WB_ALU = 7,
                 ST_ADDR = 8, ST_MEM_RD = 9, ST_MEM_WR = 10, ST_WB_MEM = 11,
                 ST_BRANCH = 12, ST_JAL = 13, ST_JALR = 14, ST_TRAP = 15;

  logic       clk;
  logic       rst_n;
  logic [3:0] dbg_state;
  int         total;
  int         bad;

  // entry = {alu_cond to drive, mem_ready to drive, expected state, expected outputs}
  logic [22:0] exp_q[$];

  control_principal_if bus ();

  control_principal dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] mk(input int modo, input int sa, input int sb,
                                     input int wb, input int pcs, input int saddr,
                                     input int pcw, input int irw, input int rw,
                                     input int mr, input int mw, input int ill);
    return {2'(modo), 2'(sa), 2'(sb), 2'(wb), 2'(pcs), 1'(saddr), 1'(pcw),
            1'(irw), 1'(rw), 1'(mr), 1'(mw), 1'(ill)};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.modo, bus.sel_a, bus.sel_b, bus.sel_wb, bus.pc_src, bus.sel_addr,
            bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_req, bus.mem_we,
            bus.illegal};
  endfunction

  task automatic push(input logic [16:0] o, input int st, input logic rdy, input logic cond);
    exp_q.push_back({cond, rdy, 4'(st), o});
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // reference model: expected cycle trace of one instruction; returns 1 if it retires
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic cond,
                       input int wf, input int wm, input int ntrap, output bit retires);
    bit trap;
    trap = 1'b0;
    retires = 1'b1;
    for (int i = 0; i < wf; i++) push(mk(0,0,0,0,0,0,0,0,0,1,0,0), ST_FETCH, 1'b0, rnd_bit());
    push(mk(0,0,0,0,0,0,0,1,0,1,0,0), ST_FETCH, 1'b1, rnd_bit());
    push(mk(0,0,0,0,0,0,0,0,0,0,0,0), ST_DECODE, rnd_bit(), rnd_bit());
    case (op)
      7'b0110011: push(mk(2,1,0,0,0,0,0,0,0,0,0,0), ST_EXEC_R, rnd_bit(), rnd_bit());
      7'b0010011: push(mk(1,1,1,0,0,0,0,0,0,0,0,0), ST_EXEC_I, rnd_bit(), rnd_bit());
      7'b0110111: push(mk(0,2,1,0,0,0,0,0,0,0,0,0), ST_LUI, rnd_bit(), rnd_bit());
      7'b0010111: push(mk(0,0,1,0,0,0,0,0,0,0,0,0), ST_AUIPC, rnd_bit(), rnd_bit());
      7'b0000011: begin
        push(mk(0,1,1,0,0,0,0,0,0,0,0,0), ST_ADDR, rnd_bit(), rnd_bit());
        for (int i = 0; i < wm; i++) push(mk(0,0,0,0,0,1,0,0,0,1,0,0), ST_MEM_RD, 1'b0, rnd_bit());
        push(mk(0,0,0,0,0,1,0,0,0,1,0,0), ST_MEM_RD, 1'b1, rnd_bit());
        push(mk(0,0,0,1,0,0,1,0,1,0,0,0), ST_WB_MEM, rnd_bit(), rnd_bit());
      end
      7'b0100011: begin
        push(mk(0,1,1,0,0,0,0,0,0,0,0,0), ST_ADDR, rnd_bit(), rnd_bit());
        for (int i = 0; i < wm; i++) push(mk(0,0,0,0,0,1,0,0,0,1,1,0), ST_MEM_WR, 1'b0, rnd_bit());
        push(mk(0,0,0,0,0,1,1,0,0,1,1,0), ST_MEM_WR, 1'b1, rnd_bit());
      end
      7'b1100011: begin
        if (f3 == 3'b010 || f3 == 3'b011) trap = 1'b1;
        else push(mk(3,1,0,0,int'(cond),0,1,0,0,0,0,0), ST_BRANCH, rnd_bit(), cond);
      end
      7'b1101111: push(mk(0,0,0,2,1,0,1,0,1,0,0,0), ST_JAL, rnd_bit(), rnd_bit());
      7'b1100111: push(mk(0,1,1,2,2,0,1,0,1,0,0,0), ST_JALR, rnd_bit(), rnd_bit());
      default: trap = 1'b1;
    endcase
    if (op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111})
      push(mk(0,0,0,0,0,0,1,0,1,0,0,0), ST_WB_ALU, rnd_bit(), rnd_bit());
    if (trap) begin
      retires = 1'b0;
      for (int i = 0; i < ntrap; i++)
        push(mk(0,0,0,0,0,0,0,0,0,0,0,1), ST_TRAP, 1'(i % 2), rnd_bit());
    end
  endtask

  // driver: plays up to n_max queued cycles, then discards the rest
  task automatic run_trace(input logic [6:0] op, input logic [2:0] f3,
                           input int n_max, input bit retires, input string name);
    logic [22:0] e;
    int pcw;
    int k;
    pcw = 0;
    k = 0;
    while (exp_q.size() > 0 && k < n_max) begin
      e = exp_q.pop_front();
      #1;
      bus.opcode    = op;
      bus.funct3    = f3;
      bus.alu_cond  = e[22];
      bus.mem_ready = e[21];
      @(negedge clk);
      total++;
      if (observed() !== e[16:0]) begin
        bad++;
        $display("FAIL %s cyc%0d outputs: got %h want %h", name, k, observed(), e[16:0]);
      end
      total++;
      if (dbg_state !== e[20:17]) begin
        bad++;
        $display("FAIL %s cyc%0d state: got %0d want %0d", name, k, dbg_state, e[20:17]);
      end
      total++;
      if (bus.reg_write === 1'b1 && bus.mem_we === 1'b1) begin
        bad++;
        $display("FAIL %s cyc%0d reg_write_and_mem_we: got 1 want 0", name, k);
      end
      if (bus.pc_write === 1'b1) pcw++;
      @(posedge clk);
      k++;
    end
    exp_q.delete();
    if (retires) begin
      total++;
      if (pcw != 1) begin
        bad++;
        $display("FAIL %s pc_write_count: got %0d want 1", name, pcw);
      end
    end
  endtask

  task automatic do_reset(input logic rdy, input string name);
    #1;
    rst_n = 1'b0;
    bus.mem_ready = rdy;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.mem_ready = rnd_bit();
    @(negedge clk);
    total++;
    if (observed() !== 17'd0) begin
      bad++;
      $display("FAIL %s reset_outputs: got %h want 0", name, observed());
    end
    total++;
    if (dbg_state !== 4'(ST_RESET)) begin
      bad++;
      $display("FAIL %s reset_state: got %0d want %0d", name, dbg_state, ST_RESET);
    end
    @(posedge clk);
  endtask

  task automatic one(input logic [6:0] op, input logic [2:0] f3, input logic cond,
                     input int wf, input int wm, input string name);
    bit r;
    build(op, f3, cond, wf, wm, 4, r);
    run_trace(op, f3, 1000, r, name);
    if (!r) do_reset(rnd_bit(), {name, "_reset"});
  endtask

  task automatic test_reset();
    do_reset(1'b1, "reset");
  endtask

  task automatic test_alu();
    one(7'b0110011, 3'b000, 1'b0, 0, 0, "alu_r");
    one(7'b0010011, 3'b001, 1'b0, 1, 0, "alu_i");
    one(7'b0110111, 3'b000, 1'b0, 0, 0, "lui");
    one(7'b0010111, 3'b000, 1'b0, 2, 0, "auipc");
  endtask

  task automatic test_load_wait();
    one(7'b0000011, 3'b010, 1'b0, 0, 3, "load_wait");
    one(7'b0100011, 3'b010, 1'b0, 0, 2, "store_wait");
  endtask

  task automatic test_branch();
    one(7'b1100011, 3'b000, 1'b1, 0, 0, "branch_taken");
    one(7'b1100011, 3'b000, 1'b0, 0, 0, "branch_not_taken");
    one(7'b1100011, 3'b011, 1'b1, 0, 0, "branch_bad_f3");
  endtask

  task automatic test_jumps();
    one(7'b1100111, 3'b000, 1'b0, 0, 0, "jalr");
    one(7'b1101111, 3'b000, 1'b0, 0, 0, "jal");
  endtask

  task automatic test_trap();
    bit r;
    build(7'b1111111, 3'b000, 1'b0, 0, 0, 20, r);
    run_trace(7'b1111111, 3'b000, 1000, r, "trap_hold");
    do_reset(1'b1, "trap_reset");
  endtask

  task automatic test_reset_mid_store();
    bit r;
    build(7'b0100011, 3'b010, 1'b0, 0, 5, 0, r);
    // FETCH, DECODE, ADDR, then two waiting MEM_WR cycles
    run_trace(7'b0100011, 3'b010, 5, 1'b0, "store_abort");
    do_reset(1'b0, "store_abort_reset");
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops[10];
    logic [6:0] op;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) op = 7'($urandom_range(0, 127));
      else op = ops[$urandom_range(0, 9)];
      one(op, 3'($urandom_range(0, 7)), rnd_bit(), $urandom_range(0, 2),
          $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.opcode = 7'd0;
    bus.funct3 = 3'd0;
    bus.alu_cond = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_jumps();
    test_trap();
    test_reset_mid_store();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
